// File: rtl/cs_compute_engine_pkg.sv
// rtl/cs_compute_engine_pkg.sv - shared types and width helpers for the compute engine
package cs_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MAX  = 3'd5,
        OP_MIN  = 3'd6,
        OP_PASS = 3'd7
    } cs_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } cs_state_e;

    localparam int OP_CODE_W = 3;
    localparam int MAX_OPS   = 8;

    function automatic int op_width(input int n_ops);
        return (n_ops <= 2) ? 1 : $clog2(n_ops);
    endfunction

endpackage

// File: rtl/cs_compute_engine_if.sv
// rtl/cs_compute_engine_if.sv - host load/read port and command handshake bundle
interface cs_compute_engine_if
    import cs_pkg::*;
#(
    parameter int MEM_WIDTH     = 8,
    parameter int MEM_DEPTH     = 16,
    parameter int NO_OPERATIONS = 4
);
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int OP_W = op_width(NO_OPERATIONS);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [MEM_WIDTH-1:0] DQ_in;
    logic [AW-1:0]        rd_addr;
    logic [MEM_WIDTH-1:0] DQ_out;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [OP_W-1:0]      operation_select;
    logic [AW-1:0]        addA;
    logic [AW-1:0]        addB;
    logic [AW-1:0]        addC;
    logic                 seq_finished;
    logic                 carry_out;
    logic                 op_err;

    modport master (
        output wr_en, wr_addr, DQ_in, rd_addr, cmd_valid, operation_select, addA, addB, addC,
        input  DQ_out, cmd_ready, seq_finished, carry_out, op_err
    );

    modport slave (
        input  wr_en, wr_addr, DQ_in, rd_addr, cmd_valid, operation_select, addA, addB, addC,
        output DQ_out, cmd_ready, seq_finished, carry_out, op_err
    );

endinterface

// File: rtl/cs_compute_engine_alu.sv
// rtl/cs_compute_engine_alu.sv - combinational ALU; CS_SATURATE_EN clamps ADD/SUB overflow
module cs_alu
    import cs_pkg::*;
#(
    parameter int MEM_WIDTH     = 8,
    parameter int NO_OPERATIONS = 4,
    localparam int OP_W         = op_width(NO_OPERATIONS)
) (
    input  logic [OP_W-1:0]      op,
    input  logic [MEM_WIDTH-1:0] a,
    input  logic [MEM_WIDTH-1:0] b,
    output logic [MEM_WIDTH-1:0] result,
    output logic                 carry,
    output logic                 invalid
);

    logic [MEM_WIDTH:0]     sum;
    logic [MEM_WIDTH:0]     diff;
    logic [OP_CODE_W-1:0]   op_ext;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        op_ext  = OP_CODE_W'(op);
        invalid = (32'(op) >= 32'(NO_OPERATIONS));
        result  = '0;
        carry   = 1'b0;
        // diff's top bit is the borrow of the unsigned subtract
        case (cs_op_e'(op_ext))
            OP_ADD: begin
                carry  = sum[MEM_WIDTH];
`ifdef CS_SATURATE_EN
                result = sum[MEM_WIDTH] ? '1 : sum[MEM_WIDTH-1:0];
`else
                result = sum[MEM_WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                carry  = diff[MEM_WIDTH];
`ifdef CS_SATURATE_EN
                result = diff[MEM_WIDTH] ? '0 : diff[MEM_WIDTH-1:0];
`else
                result = diff[MEM_WIDTH-1:0];
`endif
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MAX:  result = (a >= b) ? a : b;
            OP_MIN:  result = (a <= b) ? a : b;
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cs_compute_engine.sv
// rtl/cs_compute_engine.sv - register-memory compute engine; optional CS_SATURATE_EN in cs_alu
module cs_compute_engine
    import cs_pkg::*;
#(
    parameter int MEM_WIDTH     = 8,
    parameter int MEM_DEPTH     = 16,
    parameter int NO_OPERATIONS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cs_compute_engine_if.slave bus
);

    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int OP_W = op_width(NO_OPERATIONS);

    cs_state_e            state;
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    logic [OP_W-1:0]      op_q;
    logic [AW-1:0]        a_q, b_q, c_q;
    logic [MEM_WIDTH-1:0] opa_q, opb_q, res_q;
    logic                 carry_q, inv_q;

    logic [MEM_WIDTH-1:0] alu_res;
    logic                 alu_carry, alu_inv;

    cs_alu #(
        .MEM_WIDTH     (MEM_WIDTH),
        .NO_OPERATIONS (NO_OPERATIONS)
    ) u_alu (
        .op      (op_q),
        .a       (opa_q),
        .b       (opb_q),
        .result  (alu_res),
        .carry   (alu_carry),
        .invalid (alu_inv)
    );

    assign bus.cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            op_q             <= '0;
            a_q              <= '0;
            b_q              <= '0;
            c_q              <= '0;
            opa_q            <= '0;
            opb_q            <= '0;
            res_q            <= '0;
            carry_q          <= 1'b0;
            inv_q            <= 1'b0;
            bus.DQ_out       <= '0;
            bus.seq_finished <= 1'b0;
            bus.carry_out    <= 1'b0;
            bus.op_err       <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            // read before any write on this edge: no write-through bypass
            bus.DQ_out       <= mem[bus.rd_addr];
            bus.seq_finished <= 1'b0;
            bus.op_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_en) mem[bus.wr_addr] <= bus.DQ_in;
                    if (bus.cmd_valid) begin
                        op_q  <= bus.operation_select;
                        a_q   <= bus.addA;
                        b_q   <= bus.addB;
                        c_q   <= bus.addC;
                        state <= READ;
                    end
                end
                READ: begin
                    opa_q <= mem[a_q];
                    opb_q <= mem[b_q];
                    state <= EXEC;
                end
                EXEC: begin
                    res_q   <= alu_res;
                    carry_q <= alu_carry;
                    inv_q   <= alu_inv;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (inv_q) begin
                        bus.op_err <= 1'b1;
                    end else begin
                        mem[c_q]         <= res_q;
                        bus.seq_finished <= 1'b1;
                        bus.carry_out    <= carry_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cs_compute_engine.md
Name: cs_compute_engine

Overview:
- Parametrised successor to the single-op computation storage unit.
- Holds an internal MEM_WIDTH x MEM_DEPTH register memory and exposes a host load/read port.
- Accepts compute commands over a valid/ready handshake. Each command reads operands at addA/addB, applies the selected ALU op, writes the result to addC, then pulses seq_finished.
- Sits between the host sequencer and storage; replaces the fixed 4-op unit.

Parameters:
- MEM_WIDTH, 8, data word width in bits (>=2).
- MEM_DEPTH, 16, number of words (power of 2, >=2).
- NO_OPERATIONS, 4, number of supported ops (2..8). Op code width OP_W = max(1, $clog2(NO_OPERATIONS)).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe, honoured only when idle.
- wr_addr  in  $clog2(MEM_DEPTH)  host write address.
- DQ_in  in  MEM_WIDTH  host write data.
- rd_addr  in  $clog2(MEM_DEPTH)  host read address.
- DQ_out  out  MEM_WIDTH  registered read data.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- operation_select  in  OP_W  op code.
- addA, addB, addC  in  $clog2(MEM_DEPTH) each  operand A, operand B, destination.
- seq_finished  out  1  one-cycle pulse when the result is committed.
- carry_out  out  1  carry/borrow of the last ADD/SUB, else 0. Valid with seq_finished.
- op_err  out  1  one-cycle pulse when an op code >= NO_OPERATIONS is accepted.

Behaviour:
- Reset (async, rst_n low): all memory words = 0; DQ_out = 0; seq_finished = 0; carry_out = 0; op_err = 0; FSM = IDLE; cmd_ready = 1 once released.
- Reset mid-command: command discarded, no write, no seq_finished.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE.
- cmd_ready = (state == IDLE), combinational from state.
- Handshake: cmd_valid & cmd_ready at an edge latches op and all three addresses, then moves to READ. Host must hold stable inputs until acceptance.
- READ: latches opA = mem[addA] and opB = mem[addB] at the edge leaving READ.
- EXEC: ALU result and carry are registered.
- WRITE: mem[addC] <= result. seq_finished = 1 and carry_out updated for the following cycle; state returns to IDLE.
- Latency: seq_finished is high in the cycle after the 3rd edge following acceptance. Throughput is 1 command per 4 cycles. The next command may be accepted in the same cycle seq_finished is high.
- Op codes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR (always present).
  - 4 XOR, 5 MAX, 6 MIN, 7 PASS A (present only when NO_OPERATIONS exceeds the code).
  - MAX/MIN compare unsigned.
- Invalid op (code >= NO_OPERATIONS): runs READ/EXEC, skips the memory write, pulses op_err instead of seq_finished.
- Arithmetic: unsigned, modulo 2^MEM_WIDTH. carry_out = bit MEM_WIDTH of the add, or the borrow of the subtract.
- Aliasing: addC equal to addA or addB is legal. Operands are captured in READ, so pre-command values are used.
- Host write: occurs at the edge only if wr_en and state == IDLE; ignored while busy.
- Host write and command accepted in the same cycle: both happen. READ sees the newly written word.
- DQ_out <= mem[rd_addr] every edge (1-cycle latency). No same-edge write bypass: old data is returned.

Optional Feature:
- CS_SATURATE_EN defined: ADD clamps to all-ones on carry; SUB clamps to 0 on borrow. carry_out still reports the overflow.
- Undefined: wrap-around per the arithmetic rules above.

Decomposition:
- Package cs_pkg holds:
  - typedef enum cs_op_e for the op codes above;
  - typedef enum cs_state_e {IDLE, READ, EXEC, WRITE};
  - localparam widths derived from the parameters.
- One sub-module, cs_alu: combinational, parametrised on MEM_WIDTH/NO_OPERATIONS. Outputs result, carry and invalid flag; contains the CS_SATURATE_EN logic.

Test Plan:
- Load mem[2]=0x30, mem[5]=0x12; ADD A=2 B=5 C=7 -> seq_finished 3 edges after acceptance; rd_addr=7 gives DQ_out=0x42 one cycle later; carry_out=0.
- Load mem[0]=0xF0, mem[1]=0x20; ADD C=2 -> mem[2]=0x10, carry_out=1. With CS_SATURATE_EN: mem[2]=0xFF, carry_out=1.
- SUB 0x05-0x09 -> mem[C]=0xFC, carry_out=1. With CS_SATURATE_EN: mem[C]=0x00.
- Hold cmd_valid through a running command and pulse wr_en to addr 9 while busy -> cmd_ready low during READ/EXEC/WRITE; second command accepted only in IDLE; mem[9] unchanged.
- Aliasing: mem[3]=0x0F, mem[4]=0x3C, AND A=3 B=4 C=3 -> mem[3]=0x0C. With NO_OPERATIONS=6, op 7 -> op_err pulse, no write, no seq_finished.
- Assert rst_n low during EXEC -> all outputs 0 immediately, memory cleared, no seq_finished; cmd_ready=1 after release.
